counter_sequencer: RTL

- Command-driven controller for the 4-bit counter (enable/mode/D in; Q/rco/load out).
- Accepts queued commands {mode, D, length}, drives the counter's control inputs cycle by cycle, and monitors its rco/load outputs.
- Reports completion, rco counts and load faults.
- Sits between stimulus/CPU logic and one counter instance; it replaces direct testbench driving of tb_enable/tb_mode/tb_D.

---
 rtl/counter_seq_pkg.sv | 39 +++
 rtl/counter_sequencer_if.sv | 31 +++
 rtl/counter_sequencer_cmd_fifo.sv | 69 ++++++
 rtl/counter_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
// Mode codes, FSM encoding and packed command field layout.
package counter_seq_pkg;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam int MODE_W    = 2;
    localparam int D_W       = 4;
    localparam int CMD_HDR_W = MODE_W + D_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Command word is packed as {mode, d, len}, len in the LSBs.
    function automatic int cmd_len_lsb();
        return 0;
    endfunction

    function automatic int cmd_d_lsb(input int len_w);
        return len_w;
    endfunction

    function automatic int cmd_mode_lsb(input int len_w);
        return len_w + D_W;
    endfunction

    function automatic int cmd_width(input int len_w);
        return len_w + CMD_HDR_W;
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Command handshake bundle between a producer and the sequencer.
// Producer drives valid/payload, sequencer returns ready.
interface counter_sequencer_if
    import counter_seq_pkg::*;
#(
    parameter int LEN_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [MODE_W-1:0] cmd_mode;
    logic [D_W-1:0]    cmd_d;
    logic [LEN_W-1:0]  cmd_len;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_d,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_d,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/counter_sequencer_cmd_fifo.sv
// Synchronous command queue with flush and a registered ready flag.
// Ready is low during reset and rises on the first edge after release.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ready & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (flush) begin
            count_n = '0;
        end else if (do_push && !do_pop) begin
            count_n = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            count <= count_n;
            // Ready mirrors !full of the next cycle, so it is never stale.
            ready <= (count_n != FULL_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for a 4-bit counter: queues commands,
// drives enable/mode/D, and watches rco/load responses.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    parameter int RCO_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    counter_sequencer_if.slave cmd,
    input  logic              abort,
    output logic              cnt_enable,
    output logic [1:0]        cnt_mode,
    output logic [3:0]        cnt_D,
    input  logic              cnt_rco,
    input  logic              cnt_load,
    output logic              busy,
    output logic              cmd_done,
    output logic [RCO_W-1:0]  rco_count,
    output logic              load_err
);

    localparam int CMD_W = cmd_width(LEN_W);
    localparam int L_LSB = cmd_len_lsb();
    localparam int D_LSB = cmd_d_lsb(LEN_W);
    localparam int M_LSB = cmd_mode_lsb(LEN_W);

    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_ready;
    logic              fifo_empty;
    logic              pop;

    logic [MODE_W-1:0] head_mode;
    logic [D_W-1:0]    head_d;
    logic [LEN_W-1:0]  head_len;

    state_t            state;
    state_t            state_n;
    logic [LEN_W-1:0]  len_cnt;
    logic [LEN_W-1:0]  len_n;
    logic              en_n;
    logic [1:0]        mode_n;
    logic [3:0]        d_n;
    logic              set_err;
    logic              rco_inc;

    assign fifo_din      = {cmd.cmd_mode, cmd.cmd_d, cmd.cmd_len};
    assign cmd.cmd_ready = fifo_ready;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd.cmd_valid),
        .pop   (pop),
        .flush (abort),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .ready (fifo_ready),
        .empty (fifo_empty)
    );

    assign head_mode = fifo_dout[M_LSB +: MODE_W];
    assign head_d    = fifo_dout[D_LSB +: D_W];
    assign head_len  = fifo_dout[L_LSB +: LEN_W];

    assign cmd_done = (state == ST_DONE);
    assign busy     = (state != ST_IDLE) | ~fifo_empty;

    // Control outputs are computed for the next state and registered.
    always_comb begin
        state_n = state;
        len_n   = len_cnt;
        en_n    = 1'b0;
        mode_n  = cnt_mode;
        d_n     = cnt_D;
        pop     = 1'b0;
        set_err = 1'b0;
        rco_inc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    en_n = 1'b1;
                    if (head_mode == MODE_LOAD) begin
                        state_n = ST_LOAD;
                        mode_n  = MODE_LOAD;
                        d_n     = head_d;
                    end else begin
                        state_n = ST_RUN;
                        mode_n  = head_mode;
                        d_n     = '0;
                        len_n   = head_len;
                    end
                end
            end
            ST_LOAD: begin
                state_n = ST_CHECK;
            end
            ST_CHECK: begin
                set_err = ~cnt_load;
                state_n = ST_DONE;
            end
            ST_RUN: begin
                rco_inc = cnt_rco;
                // A zero length means run until the counter reports rco.
                if (len_cnt == '0) begin
                    if (cnt_rco) state_n = ST_DONE;
                    else         en_n    = 1'b1;
                end else if (len_cnt == LEN_W'(1)) begin
                    state_n = ST_DONE;
                end else begin
                    en_n  = 1'b1;
                    len_n = len_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_n = ST_IDLE;
            en_n    = 1'b0;
            pop     = 1'b0;
            set_err = 1'b0;
            rco_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            len_cnt    <= '0;
            cnt_enable <= 1'b0;
            cnt_mode   <= MODE_UP;
            cnt_D      <= '0;
            rco_count  <= '0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_n;
            len_cnt    <= len_n;
            cnt_enable <= en_n;
            cnt_mode   <= mode_n;
            cnt_D      <= d_n;
            if (abort) begin
                rco_count <= '0;
                load_err  <= 1'b0;
            end else begin
                if (rco_inc && rco_count != '1) rco_count <= rco_count + 1'b1;
                if (set_err) load_err <= 1'b1;
            end
        end
    end

endmodule
